// File: rtl/vga_pkg.sv
// Shared VGA constants and types for the square-animation colour stage.
package vga_pkg;

    localparam int H_RES   = 640;
    localparam int V_RES   = 480;
    localparam int COLOR_W = 4;
    localparam int X_W     = 10;
    localparam int Y_W     = 9;

    typedef struct packed {
        logic [COLOR_W-1:0] red;
        logic [COLOR_W-1:0] green;
        logic [COLOR_W-1:0] blue;
    } rgb_t;

    typedef enum logic {
        DIR_INC,
        DIR_DEC
    } dir_t;

endpackage

// File: rtl/vga_bounce_axis.sv
// One axis of the bouncing square: position/direction register that steps by
// SPEED on each enable and clamps to [0, LIMIT-SIZE], pulsing flip on a reversal.
module vga_bounce_axis
    import vga_pkg::*;
#(
    parameter int W     = 10,
    parameter int LIMIT = 640,
    parameter int SIZE  = 32,
    parameter int SPEED = 2,
    parameter int INIT  = 0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         enable,
    output logic [W-1:0] pos,
    output logic         flip
);

    localparam logic [W:0]   MAX_WIDE = (W+1)'(LIMIT - SIZE);
    localparam logic [W-1:0] MAX_POS  = W'(LIMIT - SIZE);
    localparam logic [W:0]   SPD_WIDE = (W+1)'(SPEED);
    localparam logic [W-1:0] SPD      = W'(SPEED);

    dir_t         dir;
    logic [W:0]   sum;
    logic [W-1:0] pos_next;
    logic         at_wall;

    // The sum is one bit wider so a step past the far wall cannot wrap.
    always_comb begin
        sum      = {1'b0, pos} + SPD_WIDE;
        pos_next = pos;
        at_wall  = 1'b0;
        if (dir == DIR_INC) begin
            if (sum >= MAX_WIDE) begin
                pos_next = MAX_POS;
                at_wall  = 1'b1;
            end else begin
                pos_next = sum[W-1:0];
            end
        end else begin
            if (pos <= SPD) begin
                pos_next = '0;
                at_wall  = 1'b1;
            end else begin
                pos_next = pos - SPD;
            end
        end
    end

    assign flip = enable & at_wall;

    always_ff @(posedge clock) begin
        if (reset) begin
            pos <= W'(INIT);
            dir <= DIR_INC;
        end else if (enable) begin
            pos <= pos_next;
            if (at_wall) begin
                dir <= (dir == DIR_INC) ? DIR_DEC : DIR_INC;
            end
        end
    end

endmodule

// File: rtl/vga_square_anim.sv
// Pixel-colour stage drawing a bouncing square; colour and syncs share one strobe register.
// Define VGA_SQ_GRADIENT_EN for a position-dependent background instead of black.
module vga_square_anim
    import vga_pkg::*;
#(
    parameter int          SQ_SIZE  = 32,
    parameter int          SPEED    = 2,
    parameter int          X_INIT   = 100,
    parameter int          Y_INIT   = 80,
    parameter logic [11:0] SQ_COLOR = 12'hF00
) (
    input  logic               in_clock,
    input  logic               in_reset,
    input  logic               in_strobe,
    input  logic               in_animate,
    input  logic               in_active,
    input  logic               in_hsync,
    input  logic               in_vsync,
    input  logic [X_W-1:0]     in_x,
    input  logic [Y_W-1:0]     in_y,
    output logic               out_hsync,
    output logic               out_vsync,
    output logic [COLOR_W-1:0] out_red,
    output logic [COLOR_W-1:0] out_green,
    output logic [COLOR_W-1:0] out_blue,
    output logic               out_bounce
);

    localparam logic [10:0] SZ = 11'(SQ_SIZE);

    logic           step;
    logic [X_W-1:0] sq_x;
    logic [Y_W-1:0] sq_y;
    logic           flip_x;
    logic           flip_y;
    logic [10:0]    px, py, x0, y0;
    logic           hit;
    rgb_t           background;
    rgb_t           pix;
    rgb_t           rgb_q;

    assign step = in_strobe & in_animate;

    vga_bounce_axis #(
        .W    (X_W),
        .LIMIT(H_RES),
        .SIZE (SQ_SIZE),
        .SPEED(SPEED),
        .INIT (X_INIT)
    ) axis_x (
        .clock (in_clock),
        .reset (in_reset),
        .enable(step),
        .pos   (sq_x),
        .flip  (flip_x)
    );

    vga_bounce_axis #(
        .W    (Y_W),
        .LIMIT(V_RES),
        .SIZE (SQ_SIZE),
        .SPEED(SPEED),
        .INIT (Y_INIT)
    ) axis_y (
        .clock (in_clock),
        .reset (in_reset),
        .enable(step),
        .pos   (sq_y),
        .flip  (flip_y)
    );

    assign px = 11'(in_x);
    assign py = 11'(in_y);
    assign x0 = 11'(sq_x);
    assign y0 = 11'(sq_y);

    assign hit = in_active && (px >= x0) && (px < x0 + SZ) && (py >= y0) && (py < y0 + SZ);

`ifdef VGA_SQ_GRADIENT_EN
    assign background = '{red: in_x[9:6], green: in_y[8:5], blue: 4'h4};
`else
    assign background = '0;
`endif

    always_comb begin
        pix = '0;
        if (in_active) begin
            pix = hit ? rgb_t'(SQ_COLOR) : background;
        end
    end

    // Bounce is a per-clock pulse, so it is registered outside the strobe gate.
    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            rgb_q      <= '0;
            out_hsync  <= 1'b1;
            out_vsync  <= 1'b1;
            out_bounce <= 1'b0;
        end else begin
            out_bounce <= flip_x | flip_y;
            if (in_strobe) begin
                rgb_q     <= pix;
                out_hsync <= in_hsync;
                out_vsync <= in_vsync;
            end
        end
    end

    assign out_red   = rgb_q.red;
    assign out_green = rgb_q.green;
    assign out_blue  = rgb_q.blue;

endmodule
